// File: rtl/counter_updown_pkg.sv
// Shared types and elaboration helpers for the modulo up/down counter.
// Imported by the step calculator and the counter top level.
package counter_updown_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } count_dir_t;

  // Bits needed to hold MOD_MAX+1; the datapath is one bit wider than count for this reason.
  function automatic int modulus_width(input longint mod_max);
    return $clog2(mod_max + 64'sd2);
  endfunction

  function automatic bit params_ok(input int count_width, input longint mod_max,
                                   input longint rst_value);
    bit ok;
    ok = 1'b1;
    if (count_width < 32'sd1 || count_width > 32'sd31) begin
      ok = 1'b0;
    end else if (mod_max < 64'sd1 || mod_max > ((64'sd1 <<< count_width) - 64'sd1)) begin
      ok = 1'b0;
    end else if (rst_value < 64'sd0 || rst_value > mod_max) begin
      ok = 1'b0;
    end else if (modulus_width(mod_max) > count_width + 32'sd1) begin
      ok = 1'b0;
    end else begin
      ok = 1'b1;
    end
    return ok;
  endfunction

endpackage

// File: rtl/counter_updown_if.sv
// Control and status bundle of the up/down counter; master drives the
// controls, slave (the counter) returns count and boundary status.
interface counter_updown_if #(
  parameter int COUNT_WIDTH = 8
);

  logic                   en;
  logic                   clr;
  logic                   load;
  logic [COUNT_WIDTH-1:0] load_value;
  logic                   up;
  logic [COUNT_WIDTH-1:0] step;
  logic [COUNT_WIDTH-1:0] count;
  logic                   wrap;
  logic                   sat_hit;
  logic                   at_max;
  logic                   at_min;

  modport master (
    output en, clr, load, load_value, up, step,
    input  count, wrap, sat_hit, at_max, at_min
  );

  modport slave (
    input  en, clr, load, load_value, up, step,
    output count, wrap, sat_hit, at_max, at_min
  );

endinterface

// File: rtl/counter_updown_step_calc.sv
// Combinational next-count computation for one enabled step, including
// step clamping and the wrap/saturate boundary decision.
module counter_updown_step_calc
  import counter_updown_pkg::*;
#(
  parameter int COUNT_WIDTH = 8,
  parameter int MOD_MAX     = (32'sd1 <<< COUNT_WIDTH) - 32'sd1,
  parameter int SATURATE    = 0
) (
  input  logic [COUNT_WIDTH-1:0] count,
  input  logic [COUNT_WIDTH-1:0] step,
  input  logic                   up,
  output logic [COUNT_WIDTH-1:0] next_count,
  output logic                   crossed
);

  localparam int AW = COUNT_WIDTH + 1;
  localparam logic [AW-1:0] MAX_A     = AW'(MOD_MAX);
  localparam logic [AW-1:0] MODULUS_A = AW'(longint'(MOD_MAX) + 64'sd1);
  localparam logic          SAT_MODE  = (SATURATE != 0) ? 1'b1 : 1'b0;

  count_dir_t              dir_s;
  logic       [AW-1:0]     count_a_s;
  logic       [AW-1:0]     step_eff_s;
  logic       [AW-1:0]     sum_s;

  assign dir_s      = count_dir_t'(up);
  assign count_a_s  = {1'b0, count};
  assign step_eff_s = ({1'b0, step} > MAX_A) ? MAX_A : {1'b0, step};
  assign sum_s      = count_a_s + step_eff_s;

  // Next value and boundary-crossing flag for the selected direction.
  always_comb begin
    next_count = count;
    crossed    = 1'b0;
    case (dir_s)
      DIR_UP: begin
        if (sum_s > MAX_A) begin
          crossed = 1'b1;
          if (SAT_MODE) begin
            next_count = COUNT_WIDTH'(MAX_A);
          end else begin
            next_count = COUNT_WIDTH'(sum_s - MODULUS_A);
          end
        end else begin
          next_count = COUNT_WIDTH'(sum_s);
        end
      end
      DIR_DOWN: begin
        // Adding the modulus before subtracting keeps the wrapped result non-negative.
        if (step_eff_s > count_a_s) begin
          crossed = 1'b1;
          if (SAT_MODE) begin
            next_count = {COUNT_WIDTH{1'b0}};
          end else begin
            next_count = COUNT_WIDTH'(count_a_s + MODULUS_A - step_eff_s);
          end
        end else begin
          next_count = COUNT_WIDTH'(count_a_s - step_eff_s);
        end
      end
      default: begin
        next_count = count;
        crossed    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/counter_updown.sv
// Modulo up/down counter with load, clear, programmable step and
// wrap-or-saturate behaviour; registered count and boundary pulses.
module counter_updown
  import counter_updown_pkg::*;
#(
  parameter int COUNT_WIDTH = 8,
  parameter int MOD_MAX     = (32'sd1 <<< COUNT_WIDTH) - 32'sd1,
  parameter int SATURATE    = 0,
  parameter int RST_VALUE   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  counter_updown_if.slave  bus
);

  if (!params_ok(COUNT_WIDTH, longint'(MOD_MAX), longint'(RST_VALUE))) begin : g_param_err
    $error("counter_updown: illegal COUNT_WIDTH/MOD_MAX/RST_VALUE combination");
  end

  localparam logic [COUNT_WIDTH-1:0] MAX_W    = COUNT_WIDTH'(MOD_MAX);
  localparam logic [COUNT_WIDTH-1:0] RST_W    = COUNT_WIDTH'(RST_VALUE);
  localparam logic                   SAT_MODE = (SATURATE != 0) ? 1'b1 : 1'b0;

  logic [COUNT_WIDTH-1:0] count_r;
  logic                   wrap_r;
  logic                   sat_hit_r;
  logic [COUNT_WIDTH-1:0] next_s;
  logic                   crossed_s;
  logic [COUNT_WIDTH-1:0] load_clamp_s;

  counter_updown_step_calc #(
    .COUNT_WIDTH (COUNT_WIDTH),
    .MOD_MAX     (MOD_MAX),
    .SATURATE    (SATURATE)
  ) u_step_calc (
    .count      (count_r),
    .step       (bus.step),
    .up         (bus.up),
    .next_count (next_s),
    .crossed    (crossed_s)
  );

  assign load_clamp_s = (bus.load_value > MAX_W) ? MAX_W : bus.load_value;

  // Count register and boundary pulses; reset, clear, load and step in priority order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_r   <= RST_W;
      wrap_r    <= 1'b0;
      sat_hit_r <= 1'b0;
    end else if (bus.clr) begin
      count_r   <= {COUNT_WIDTH{1'b0}};
      wrap_r    <= 1'b0;
      sat_hit_r <= 1'b0;
    end else if (bus.load) begin
      count_r   <= load_clamp_s;
      wrap_r    <= 1'b0;
      sat_hit_r <= 1'b0;
    end else if (bus.en) begin
      // Only the pulse belonging to the configured mode can ever be set.
      count_r   <= next_s;
      wrap_r    <= crossed_s & ~SAT_MODE;
      sat_hit_r <= crossed_s & SAT_MODE;
    end else begin
      count_r   <= count_r;
      wrap_r    <= 1'b0;
      sat_hit_r <= 1'b0;
    end
  end

  assign bus.count   = count_r;
  assign bus.wrap    = wrap_r;
  assign bus.sat_hit = sat_hit_r;
  assign bus.at_max  = (count_r == MAX_W);
  assign bus.at_min  = (count_r == {COUNT_WIDTH{1'b0}});

endmodule

// File: tb/tb_counter_updown.sv
// Scoreboard bench: three counter builds driven together, expected results
// queued by an arithmetic reference model and checked by a monitor.
module tb_counter_updown;

  typedef struct {
    int cnt;
    bit pulse;
  } res_t;

  typedef struct {
    int a_cnt;
    bit a_wrap;
    int b_cnt;
    bit b_sat;
    int c_cnt;
    bit c_wrap;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  counter_updown_if #(.COUNT_WIDTH(4)) ifa ();
  counter_updown_if #(.COUNT_WIDTH(4)) ifb ();
  counter_updown_if #(.COUNT_WIDTH(8)) ifc ();

  counter_updown #(.COUNT_WIDTH(4), .MOD_MAX(9), .SATURATE(0), .RST_VALUE(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa));
  counter_updown #(.COUNT_WIDTH(4), .MOD_MAX(9), .SATURATE(1), .RST_VALUE(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb));
  counter_updown #(.COUNT_WIDTH(8)) dut_c (
    .clk(clk), .rst_n(rst_n), .bus(ifc));

  exp_t q[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;
  int   ma = 0;
  int   mb = 0;
  int   mc = 0;

  // Reference: modular arithmetic for wrap builds, clamping for saturate builds.
  function automatic res_t ref_next(int cur, int m, bit sat, int rstv, bit rn, bit e,
                                    bit c, bit l, int lv, bit u, int s);
    res_t r;
    int se;
    r.cnt = cur;
    r.pulse = 1'b0;
    se = (s > m) ? m : s;
    if (!rn) r.cnt = rstv;
    else if (c) r.cnt = 0;
    else if (l) r.cnt = (lv > m) ? m : lv;
    else if (e) begin
      if (u) begin
        r.pulse = (cur + se > m);
        if (sat) r.cnt = (cur + se > m) ? m : cur + se;
        else     r.cnt = (cur + se) % (m + 1);
      end else begin
        r.pulse = (se > cur);
        if (sat) r.cnt = (se > cur) ? 0 : cur - se;
        else     r.cnt = (cur - se + m + 1) % (m + 1);
      end
    end
    return r;
  endfunction

  task automatic cyc(input bit rn, input bit e, input bit c, input bit l, input int lv,
                     input bit u, input int st, input int clv, input int cst);
    res_t ra, rb, rc;
    exp_t x;
    @(negedge clk);
    rst_n = rn;
    ifa.en = e; ifa.clr = c; ifa.load = l; ifa.up = u;
    ifa.load_value = 4'(lv); ifa.step = 4'(st);
    ifb.en = e; ifb.clr = c; ifb.load = l; ifb.up = u;
    ifb.load_value = 4'(lv); ifb.step = 4'(st);
    ifc.en = e; ifc.clr = c; ifc.load = l; ifc.up = u;
    ifc.load_value = 8'(clv); ifc.step = 8'(cst);
    ra = ref_next(ma, 9, 1'b0, 0, rn, e, c, l, lv, u, st);
    rb = ref_next(mb, 9, 1'b1, 3, rn, e, c, l, lv, u, st);
    rc = ref_next(mc, 255, 1'b0, 0, rn, e, c, l, clv, u, cst);
    ma = ra.cnt; mb = rb.cnt; mc = rc.cnt;
    x.a_cnt = ra.cnt; x.a_wrap = ra.pulse;
    x.b_cnt = rb.cnt; x.b_sat = rb.pulse;
    x.c_cnt = rc.cnt; x.c_wrap = rc.pulse;
    q.push_back(x);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (vector %0d)", name, act, exp, vectors);
    end
  endtask

  // Monitor: compare every settled output set against the oldest queued expectation.
  always @(posedge clk) begin
    #1;
    if (q.size() != 0) begin
      mon_e = q.pop_front();
      vectors++;
      chk("a_count",   int'(ifa.count),   mon_e.a_cnt);
      chk("a_wrap",    int'(ifa.wrap),    int'(mon_e.a_wrap));
      chk("a_sat_hit", int'(ifa.sat_hit), 0);
      chk("a_at_max",  int'(ifa.at_max),  int'(mon_e.a_cnt == 9));
      chk("a_at_min",  int'(ifa.at_min),  int'(mon_e.a_cnt == 0));
      chk("b_count",   int'(ifb.count),   mon_e.b_cnt);
      chk("b_sat_hit", int'(ifb.sat_hit), int'(mon_e.b_sat));
      chk("b_wrap",    int'(ifb.wrap),    0);
      chk("b_at_max",  int'(ifb.at_max),  int'(mon_e.b_cnt == 9));
      chk("b_at_min",  int'(ifb.at_min),  int'(mon_e.b_cnt == 0));
      chk("c_count",   int'(ifc.count),   mon_e.c_cnt);
      chk("c_wrap",    int'(ifc.wrap),    int'(mon_e.c_wrap));
      chk("c_at_max",  int'(ifc.at_max),  int'(mon_e.c_cnt == 255));
      chk("c_at_min",  int'(ifc.at_min),  int'(mon_e.c_cnt == 0));
    end
  end

  initial begin
    int budget;
    rst_n = 1'b0;
    ifa.en = 1'b0; ifa.clr = 1'b0; ifa.load = 1'b0; ifa.up = 1'b1;
    ifa.load_value = 4'd0; ifa.step = 4'd0;
    ifb.en = 1'b0; ifb.clr = 1'b0; ifb.load = 1'b0; ifb.up = 1'b1;
    ifb.load_value = 4'd0; ifb.step = 4'd0;
    ifc.en = 1'b0; ifc.clr = 1'b0; ifc.load = 1'b0; ifc.up = 1'b1;
    ifc.load_value = 8'd0; ifc.step = 8'd0;

    // Reset held two edges with counting requested, then release.
    repeat (2) cyc(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1, 0, 1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1, 0, 1);
    // Decade count from zero: wrap on the return to 0.
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b1, 1, 0, 1);
    repeat (10) cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1, 0, 1);
    // Down by 3 from 2, twice.
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 2, 1'b0, 0, 2, 0);
    repeat (2) cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 3, 0, 3);
    // Priority and clamping.
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 5, 1'b1, 1, 5, 1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 12, 1'b1, 0, 12, 0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b1, 15, 0, 15);
    // Reset in the middle of counting.
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 6, 1'b1, 0, 6, 0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1, 0, 1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1, 0, 1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1, 0, 1);
    // Hold: disabled with non-zero step, then enabled with zero step.
    repeat (5) cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1, 4, 0, 4);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b1, 0, 0, 0);
    // Full-width wrap 255 -> 0 on the default build.
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 9, 1'b1, 0, 255, 0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1, 0, 1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1, 0, 1);

    // Randomised traffic with occasional reset, clear and load.
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 49) != 0, $urandom_range(0, 3) != 0,
          $urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0,
          int'($urandom_range(0, 15)), $urandom_range(0, 1) == 1,
          int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
          ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                      : int'($urandom_range(0, 3)));
    end

    budget = 0;
    while (q.size() != 0 && budget < 5) begin
      @(posedge clk);
      #2;
      budget++;
    end
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
